// File: rtl/fg_config_loader_pkg.sv
// Shared definitions for the function-generator configuration loader: FSM states,
// byte width and the bit positions of the configuration fields consumed by the core.
package fg_config_loader_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StCheck   = 2'd2,
        StPending = 2'd3
    } state_e;

    localparam int unsigned ByteWidth             = 8;
    localparam int unsigned CfgRegBitwidthDefault = 64;

    localparam int unsigned FieldFreqLsb   = 0;
    localparam int unsigned FieldFreqW     = 32;
    localparam int unsigned FieldPhaseLsb  = 32;
    localparam int unsigned FieldPhaseW    = 16;
    localparam int unsigned FieldAmpLsb    = 48;
    localparam int unsigned FieldAmpW      = 8;
    localparam int unsigned FieldWaveLsb   = 56;
    localparam int unsigned FieldWaveW     = 8;

endpackage

// File: rtl/fg_idle_timer.sv
// Idle-cycle counter for the loader: cleared on activity, counts idle cycles and flags
// expiry on the cycle whose count reaches TIMEOUT_CYCLES.
module fg_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (count_i) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Expiry coincides with the edge that would bring the count to TIMEOUT_CYCLES.
    assign expire_o = count_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fg_config_loader.sv
// Byte-stream configuration loader with deferred atomic commit to the generator core.
// Optional checksum byte per frame when FG_CONFIG_CHECKSUM_EN is defined.
module fg_config_loader
    import fg_config_loader_pkg::*;
#(
    parameter int unsigned                   CONFIG_REG_BITWIDTH = CfgRegBitwidthDefault,
    parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_CONFIG       = '0,
    parameter int unsigned                   TIMEOUT_CYCLES      = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ByteWidth-1:0]           wrData_i,
    input  logic                           wrValid_i,
    output logic                           wrReady_o,
    input  logic                           outputEnable_i,
    input  logic                           strobe_i,
    output logic [CONFIG_REG_BITWIDTH-1:0] cfg_o,
    output logic                           busy_o,
    output logic                           committed_o,
    output logic                           error_o
);

    localparam int unsigned NBytes = CONFIG_REG_BITWIDTH / ByteWidth;
    localparam int unsigned CntW   = $clog2(NBytes + 1);

    state_e                         state_q;
    logic [CONFIG_REG_BITWIDTH-1:0] shadow_q;
    logic [CONFIG_REG_BITWIDTH-1:0] cfg_q;
    logic [CntW-1:0]                byte_cnt_q;
    logic [CntW-1:0]                byte_cnt_nxt;
    logic                           committed_q;
    logic                           error_q;
    logic                           accept;
    logic                           in_frame;
    logic                           expire;
    state_e                         after_data;

`ifdef FG_CONFIG_CHECKSUM_EN
    logic [ByteWidth-1:0] csum_q;
    assign after_data = StCheck;
`else
    assign after_data = StPending;
`endif

    assign wrReady_o    = (state_q != StPending);
    assign busy_o       = (state_q != StIdle);
    assign cfg_o        = cfg_q;
    assign committed_o  = committed_q;
    assign error_o      = error_q;
    assign accept       = wrValid_i && wrReady_o;
    assign in_frame     = (state_q == StLoad) || (state_q == StCheck);
    assign byte_cnt_nxt = byte_cnt_q + CntW'(1);

    fg_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (accept || !in_frame),
        .count_i (in_frame && !accept),
        .expire_o(expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            cfg_q       <= RESET_CONFIG;
            byte_cnt_q  <= '0;
            committed_q <= 1'b0;
            error_q     <= 1'b0;
`ifdef FG_CONFIG_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            committed_q <= 1'b0;
            error_q     <= 1'b0;
            unique case (state_q)
                StIdle, StLoad: begin
                    if (accept) begin
                        shadow_q <= (shadow_q << ByteWidth) | CONFIG_REG_BITWIDTH'(wrData_i);
`ifdef FG_CONFIG_CHECKSUM_EN
                        csum_q   <= ((state_q == StIdle) ? '0 : csum_q) ^ wrData_i;
`endif
                        if (byte_cnt_nxt == CntW'(NBytes)) begin
                            byte_cnt_q <= '0;
                            state_q    <= after_data;
                        end else begin
                            byte_cnt_q <= byte_cnt_nxt;
                            state_q    <= StLoad;
                        end
                    end else if (expire) begin
                        byte_cnt_q <= '0;
                        error_q    <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
`ifdef FG_CONFIG_CHECKSUM_EN
                StCheck: begin
                    if (accept) begin
                        if (wrData_i == csum_q) begin
                            state_q <= StPending;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else if (expire) begin
                        error_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
`endif
                StPending: begin
                    // Safe point: core not consuming output, or it just took a sample.
                    if (!outputEnable_i || strobe_i) begin
                        cfg_q       <= shadow_q;
                        committed_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
